// File: rtl/alu_writeback.sv
// Writeback stage behind the 16-bit ALU: in-order result FIFO, register-file commit,
// architectural HI/LO, MFHI/MFLO service, divide-by-zero saturation and sticky error flag.
module alu_writeback #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0] in_out,
    input  logic [DATA_W-1:0] in_hi,
    input  logic [DATA_W-1:0] in_lo,
    input  logic              in_div0,
    input  logic              rf_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [DATA_W-1:0] hi_q,
    output logic [DATA_W-1:0] lo_q,
    output logic              zero_flag,
    output logic              div0_err,
    input  logic              clr_err
);

    localparam int PW = $clog2(DEPTH);

    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_MFHI = 3'b110;
    localparam logic [2:0] OP_MFLO = 3'b111;

    typedef struct packed {
        logic [2:0]        op;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            in_entry;
    entry_t            head;
    logic [PW:0]       wr_ptr;
    logic [PW:0]       rd_ptr;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              head_mul;
    logic              div0_push;
    logic [DATA_W-1:0] commit_data;

    // Same index with opposite wrap bits means every slot is occupied.
    assign full  = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
    assign empty = (wr_ptr == rd_ptr);

    assign in_ready  = !full;
    assign push      = in_valid && !full;
    assign head      = mem[rd_ptr[PW-1:0]];
    assign head_mul  = (head.op == OP_MUL);
    assign pop       = !empty && (head_mul || rf_ready);
    assign div0_push = push && (in_op == OP_DIV) && in_div0;

    always_comb begin
        in_entry.op   = in_op;
        in_entry.rd   = in_rd;
        in_entry.data = div0_push ? {DATA_W{1'b1}} : in_out;
        in_entry.hi   = in_hi;
        in_entry.lo   = in_lo;
    end

    // MFHI/MFLO read the architectural registers at commit time, so any older MUL
    // has already landed because commits are strictly in order.
    always_comb begin
        case (head.op)
            OP_MFHI: commit_data = hi_q;
            OP_MFLO: commit_data = lo_q;
            default: commit_data = head.data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= in_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            zero_flag <= 1'b0;
        end else begin
            rf_we <= pop && !head_mul;
            if (pop) begin
                if (head_mul) begin
                    hi_q      <= head.hi;
                    lo_q      <= head.lo;
                    zero_flag <= ({head.hi, head.lo} == '0);
                end else begin
                    rf_waddr  <= head.rd;
                    rf_wdata  <= commit_data;
                    zero_flag <= (commit_data == '0);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)            div0_err <= 1'b0;
        else if (div0_push) div0_err <= 1'b1;
        else if (clr_err)   div0_err <= 1'b0;
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_alu_writeback;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [ADDR_W-1:0] in_rd;
    logic [DATA_W-1:0] in_out;
    logic [DATA_W-1:0] in_hi;
    logic [DATA_W-1:0] in_lo;
    logic              in_div0;
    logic              rf_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic              zero_flag;
    logic              div0_err;
    logic              clr_err;

    int n_cmp = 0;
    int n_bad = 0;

    alu_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_out(in_out), .in_hi(in_hi), .in_lo(in_lo),
        .in_div0(in_div0), .rf_ready(rf_ready), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .hi_q(hi_q), .lo_q(lo_q), .zero_flag(zero_flag),
        .div0_err(div0_err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [ADDR_W-1:0] rd,
                         input logic [DATA_W-1:0] o, input logic [DATA_W-1:0] h,
                         input logic [DATA_W-1:0] l, input logic d0);
        in_valid = v; in_op = op; in_rd = rd; in_out = o; in_hi = h; in_lo = l; in_div0 = d0;
    endtask

    task automatic idle();
        drive(1'b0, 3'b000, '0, '0, '0, '0, 1'b0);
    endtask

    task automatic test_reset();
        idle(); rf_ready = 1'b1; clr_err = 1'b0; rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_cmp++;
        if ({in_ready, rf_we, rf_waddr, rf_wdata, hi_q, lo_q, zero_flag, div0_err} !==
            {1'b1, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_state: got rdy=%b we=%b wa=%0d wd=%h hi=%h lo=%h z=%b e=%b, want 1 0 0 0000 0000 0000 0 0",
                     in_ready, rf_we, rf_waddr, rf_wdata, hi_q, lo_q, zero_flag, div0_err);
        end
    endtask

    task automatic test_add();
        drive(1'b1, 3'b000, 3'd3, 16'h1234, 16'h0, 16'h0, 1'b0);
        tick();
        idle();
        n_cmp++;
        if (rf_we !== 1'b0) begin
            n_bad++; $display("FAIL add_not_before_commit: rf_we=%b want 0", rf_we);
        end
        tick();
        n_cmp++;
        if ({rf_we, rf_waddr, rf_wdata, zero_flag} !== {1'b1, 3'd3, 16'h1234, 1'b0}) begin
            n_bad++;
            $display("FAIL add_commit: got we=%b wa=%0d wd=%h z=%b want 1 3 1234 0", rf_we, rf_waddr, rf_wdata, zero_flag);
        end
        tick();
        n_cmp++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 3'd3, 16'h1234}) begin
            n_bad++;
            $display("FAIL add_hold: got we=%b wa=%0d wd=%h want 0 3 1234", rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_mul_mf();
        drive(1'b1, 3'b010, 3'd7, 16'hDEAD, 16'h0001, 16'h8000, 1'b0);
        tick();
        drive(1'b1, 3'b110, 3'd1, 16'hBEEF, 16'h5555, 16'h5555, 1'b0);
        tick();
        n_cmp++;
        if ({rf_we, hi_q, lo_q} !== {1'b0, 16'h0001, 16'h8000}) begin
            n_bad++; $display("FAIL mul_commit: got we=%b hi=%h lo=%h want 0 0001 8000", rf_we, hi_q, lo_q);
        end
        drive(1'b1, 3'b111, 3'd2, 16'hBEEF, 16'h5555, 16'h5555, 1'b0);
        tick();
        idle();
        n_cmp++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd1, 16'h0001}) begin
            n_bad++; $display("FAIL mfhi_commit: got we=%b wa=%0d wd=%h want 1 1 0001", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        n_cmp++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd2, 16'h8000}) begin
            n_bad++; $display("FAIL mflo_commit: got we=%b wa=%0d wd=%h want 1 2 8000", rf_we, rf_waddr, rf_wdata);
        end
        tick();
    endtask

    task automatic test_stall();
        rf_ready = 1'b0;
        drive(1'b1, 3'b101, 3'd4, 16'h00A1, 16'h0, 16'h0, 1'b0);
        tick();
        drive(1'b1, 3'b101, 3'd4, 16'h00A2, 16'h0, 16'h0, 1'b0);
        tick();
        n_cmp++;
        if ({in_ready, rf_we} !== 2'b00) begin
            n_bad++; $display("FAIL stall_full: got rdy=%b we=%b want 0 0", in_ready, rf_we);
        end
        drive(1'b1, 3'b101, 3'd4, 16'h00A3, 16'h0, 16'h0, 1'b0);
        tick();
        n_cmp++;
        if ({in_ready, rf_we} !== 2'b00) begin
            n_bad++; $display("FAIL stall_hold: got rdy=%b we=%b want 0 0", in_ready, rf_we);
        end
        rf_ready = 1'b1;
        tick();
        n_cmp++;
        if ({rf_we, rf_wdata, in_ready} !== {1'b1, 16'h00A1, 1'b1}) begin
            n_bad++; $display("FAIL stall_drain1: got we=%b wd=%h rdy=%b want 1 00a1 1", rf_we, rf_wdata, in_ready);
        end
        tick();
        idle();
        n_cmp++;
        if ({rf_we, rf_wdata} !== {1'b1, 16'h00A2}) begin
            n_bad++; $display("FAIL stall_drain2: got we=%b wd=%h want 1 00a2", rf_we, rf_wdata);
        end
        tick();
        n_cmp++;
        if ({rf_we, rf_wdata} !== {1'b1, 16'h00A3}) begin
            n_bad++; $display("FAIL stall_third: got we=%b wd=%h want 1 00a3", rf_we, rf_wdata);
        end
        tick();
    endtask

    task automatic test_div0();
        drive(1'b1, 3'b011, 3'd6, 16'h0003, 16'h0, 16'h0, 1'b0);
        tick();
        drive(1'b1, 3'b011, 3'd5, 16'h0007, 16'h0, 16'h0, 1'b1);
        tick();
        idle();
        n_cmp++;
        if ({rf_we, rf_waddr, rf_wdata, div0_err} !== {1'b1, 3'd6, 16'h0003, 1'b1}) begin
            n_bad++; $display("FAIL div_ok_and_err_set: got we=%b wa=%0d wd=%h err=%b want 1 6 0003 1",
                              rf_we, rf_waddr, rf_wdata, div0_err);
        end
        tick();
        n_cmp++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd5, 16'hFFFF}) begin
            n_bad++; $display("FAIL div0_saturate: got we=%b wa=%0d wd=%h want 1 5 ffff", rf_we, rf_waddr, rf_wdata);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n_cmp++;
        if (div0_err !== 1'b0) begin
            n_bad++; $display("FAIL div0_clear: got err=%b want 0", div0_err);
        end
        clr_err = 1'b1;
        drive(1'b1, 3'b011, 3'd5, 16'h0001, 16'h0, 16'h0, 1'b1);
        tick();
        clr_err = 1'b0;
        idle();
        n_cmp++;
        if (div0_err !== 1'b1) begin
            n_bad++; $display("FAIL div0_set_priority: got err=%b want 1", div0_err);
        end
        tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic test_zero();
        drive(1'b1, 3'b001, 3'd7, 16'h0000, 16'h0, 16'h0, 1'b0);
        tick();
        drive(1'b1, 3'b000, 3'd7, 16'h0005, 16'h0, 16'h0, 1'b0);
        tick();
        n_cmp++;
        if ({rf_we, rf_wdata, zero_flag} !== {1'b1, 16'h0000, 1'b1}) begin
            n_bad++; $display("FAIL sub_zero: got we=%b wd=%h z=%b want 1 0000 1", rf_we, rf_wdata, zero_flag);
        end
        drive(1'b1, 3'b010, 3'd0, 16'h0, 16'h0000, 16'h0001, 1'b0);
        tick();
        n_cmp++;
        if (zero_flag !== 1'b0) begin
            n_bad++; $display("FAIL add_nonzero: got z=%b want 0", zero_flag);
        end
        rf_ready = 1'b0;
        drive(1'b1, 3'b010, 3'd0, 16'h1111, 16'h0000, 16'h0000, 1'b0);
        tick();
        idle();
        n_cmp++;
        if ({rf_we, hi_q, lo_q, zero_flag} !== {1'b0, 16'h0000, 16'h0001, 1'b0}) begin
            n_bad++; $display("FAIL mul_lo_only: got we=%b hi=%h lo=%h z=%b want 0 0000 0001 0", rf_we, hi_q, lo_q, zero_flag);
        end
        tick();
        n_cmp++;
        if ({rf_we, hi_q, lo_q, zero_flag} !== {1'b0, 16'h0000, 16'h0000, 1'b1}) begin
            n_bad++; $display("FAIL mul_zero_stalled: got we=%b hi=%h lo=%h z=%b want 0 0000 0000 1", rf_we, hi_q, lo_q, zero_flag);
        end
        rf_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 3'b010, 3'd0, 16'h0, 16'h1234, 16'h5678, 1'b0);
        tick();
        rf_ready = 1'b0;
        drive(1'b1, 3'b011, 3'd2, 16'h0, 16'h0, 16'h0, 1'b1);
        tick();
        drive(1'b1, 3'b101, 3'd3, 16'h00CC, 16'h0, 16'h0, 1'b0);
        tick();
        idle();
        n_cmp++;
        if ({in_ready, div0_err, hi_q} !== {1'b0, 1'b1, 16'h1234}) begin
            n_bad++; $display("FAIL pre_reset_full: got rdy=%b err=%b hi=%h want 0 1 1234", in_ready, div0_err, hi_q);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({in_ready, rf_we, rf_waddr, rf_wdata, hi_q, lo_q, zero_flag, div0_err} !==
            {1'b1, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_mid: got rdy=%b we=%b wa=%0d wd=%h hi=%h lo=%h z=%b e=%b want 1 0 0 0000 0000 0000 0 0",
                     in_ready, rf_we, rf_waddr, rf_wdata, hi_q, lo_q, zero_flag, div0_err);
        end
        rf_ready = 1'b1;
        tick();
        n_cmp++;
        if ({rf_we, rf_wdata} !== {1'b0, 16'h0}) begin
            n_bad++; $display("FAIL reset_drops_entries: got we=%b wd=%h want 0 0000", rf_we, rf_wdata);
        end
    endtask

    // Reference model: pending results as a queue, architectural state as plain variables.
    typedef struct {
        logic [2:0]        op;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } item_t;

    task automatic test_random();
        item_t             q[$];
        item_t             it;
        logic              m_we, m_zero, m_err, do_push;
        logic [ADDR_W-1:0] m_wa;
        logic [DATA_W-1:0] m_wd, m_hi, m_lo;

        rst = 1'b1; idle(); clr_err = 1'b0; tick(); rst = 1'b0;
        m_we = 0; m_zero = 0; m_err = 0; m_wa = '0; m_wd = '0; m_hi = '0; m_lo = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            drive($urandom_range(0, 2) != 0, 3'($urandom), 3'($urandom),
                  ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom),
                  ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom),
                  ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom),
                  $urandom_range(0, 1) == 1);
            rf_ready = $urandom_range(0, 3) != 0;
            clr_err  = $urandom_range(0, 5) == 0;
            rst      = $urandom_range(0, 60) == 0;
            #1;
            n_cmp++;
            if (in_ready !== (q.size() < DEPTH)) begin
                n_bad++; $display("FAIL rand_ready cyc %0d: got %b want %b", cyc, in_ready, q.size() < DEPTH);
            end
            if (rst) begin
                q.delete();
                m_we = 0; m_zero = 0; m_err = 0; m_wa = '0; m_wd = '0; m_hi = '0; m_lo = '0;
            end else begin
                do_push = in_valid && (q.size() < DEPTH);
                m_we = 0;
                if (q.size() > 0 && (q[0].op == 3'b010 || rf_ready)) begin
                    it = q.pop_front();
                    if (it.op == 3'b010) begin
                        m_hi = it.hi; m_lo = it.lo; m_zero = (it.hi == 0 && it.lo == 0);
                    end else begin
                        m_we = 1; m_wa = it.rd;
                        m_wd = (it.op == 3'b110) ? m_hi : (it.op == 3'b111) ? m_lo : it.data;
                        m_zero = (m_wd == 0);
                    end
                end
                if (do_push) begin
                    it.op = in_op; it.rd = in_rd; it.hi = in_hi; it.lo = in_lo;
                    it.data = (in_op == 3'b011 && in_div0) ? 16'hFFFF : in_out;
                    q.push_back(it);
                end
                if (do_push && in_op == 3'b011 && in_div0) m_err = 1;
                else if (clr_err)                          m_err = 0;
            end
            tick();
            n_cmp++;
            if ({rf_we, rf_waddr, rf_wdata, hi_q, lo_q, zero_flag, div0_err} !==
                {m_we, m_wa, m_wd, m_hi, m_lo, m_zero, m_err}) begin
                n_bad++;
                $display("FAIL rand_state cyc %0d: got we=%b wa=%0d wd=%h hi=%h lo=%h z=%b e=%b want %b %0d %h %h %h %b %b",
                         cyc, rf_we, rf_waddr, rf_wdata, hi_q, lo_q, zero_flag, div0_err,
                         m_we, m_wa, m_wd, m_hi, m_lo, m_zero, m_err);
            end
        end
        rst = 1'b0; clr_err = 1'b0; idle();
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul_mf();
        test_stall();
        test_div0();
        test_zero();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
